iof_arbiter: RTL and testbench

IOF_ARBITER -- requirements
Module: iof_arbiter

---
 rtl/iof_pkg.sv | 18 +
 rtl/iof_rr_pick.sv | 15 +
 rtl/iof_arbiter.sv | 105 ++++++++++
 tb/tb_iof_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iof_pkg.sv
// iof_pkg: command codes, result codes and FSM states shared by the focus-list arbiter
package iof_pkg;
  localparam logic [6:0] CMD_NOP    = 7'd0;
  localparam logic [6:0] CMD_INSERT = 7'd16;
  localparam logic [6:0] CMD_REMOVE = 7'd17;
  localparam logic [6:0] CMD_GETNXT = 7'd18;
  localparam logic [6:0] CMD_GETPRV = 7'd19;
  localparam logic [6:0] RES_DUP    = 7'h7D;
  localparam logic [6:0] RES_ILL    = 7'h7E;
  localparam logic [6:0] RES_TMO    = 7'h7F;
  localparam logic [6:0] TID_NONE   = 7'h7F;
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_WAIT, S_REFRESH, S_RCHECK, S_RWAIT, S_RESP
  } state_t;
  function automatic logic is_legal(input logic [6:0] c);
    return c >= CMD_INSERT && c <= CMD_GETPRV;
  endfunction
endpackage

// File: rtl/iof_rr_pick.sv
// iof_rr_pick: one-hot round-robin grant, searching upward from one past the last grant
module iof_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] grant
);
  logic [N-1:0] above, pool;
  always_comb begin
    above = ~((last << 1) - N'(1));
    pool  = |(req & above) ? req & above : req;
    grant = pool & (~pool + N'(1));
  end
endmodule

// File: rtl/iof_arbiter.sv
// iof_arbiter: round-robin arbiter serialising port commands onto a shared focus list
module iof_arbiter
  import iof_pkg::*;
#(
  parameter int NPORT   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NPORT-1:0]   req_i,
  input  logic [7*NPORT-1:0] cmd_i,
  input  logic [6*NPORT-1:0] tid_i,
  output logic [NPORT-1:0]   ack_o,
  output logic [6:0]         res_o,
  output logic               busy_o,
  output logic [6:0]         lst_cmd_o,
  output logic [5:0]         lst_tid_o,
  input  logic [6:0]         lst_tid_i,
  input  logic               lst_done_i,
  output logic [6:0]         focus_o,
  output logic               err_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [NPORT-1:0] pick, gnt, last;
  logic [6:0] cmd, res, cnt, sel_cmd;
  logic [5:0] tid, sel_tid;
  logic [WW-1:0] wcnt;
  logic chk, rf;
  // the port being acked still holds its request this cycle, so keep it out of the next pick
  iof_rr_pick #(.N(NPORT)) u_pick (.req(req_i & ~ack_o), .last(last), .grant(pick));
  always_comb begin
    sel_cmd = '0;
    sel_tid = '0;
    for (int n = 0; n < NPORT; n++) begin
      sel_cmd |= pick[n] ? cmd_i[7*n +: 7] : '0;
      sel_tid |= pick[n] ? tid_i[6*n +: 6] : '0;
    end
  end
  assign chk       = state == S_CHECK || state == S_RCHECK;
  assign rf        = state == S_RCHECK || state == S_RWAIT;
  assign busy_o    = state != S_IDLE;
  assign lst_cmd_o = state == S_ISSUE ? cmd : state == S_REFRESH ? CMD_GETNXT : CMD_NOP;
  assign lst_tid_o = state == S_ISSUE || state == S_REFRESH ? tid : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      ack_o   <= '0;
      res_o   <= '0;
      focus_o <= TID_NONE;
      cnt     <= '0;
      err_o   <= 1'b0;
      last    <= NPORT'(1) << (NPORT - 1);
      gnt     <= '0;
      cmd     <= CMD_NOP;
      tid     <= '0;
      res     <= '0;
      wcnt    <= '0;
    end else begin
      ack_o <= '0;
      case (state)
        S_IDLE: if (lst_done_i && |pick) begin
          gnt   <= pick;
          cmd   <= sel_cmd;
          tid   <= sel_tid;
          res   <= RES_ILL;
          state <= is_legal(sel_cmd) ? S_ISSUE : S_RESP;
        end
        S_ISSUE: state <= S_CHECK;
        S_REFRESH: state <= S_RCHECK;
        S_RESP: begin
          ack_o <= gnt;
          res_o <= res;
          last  <= gnt;
          state <= S_IDLE;
        end
        default: begin
          wcnt <= chk ? '0 : wcnt + WW'(1);
          if (lst_done_i) begin
            state <= S_RESP;
            if (rf || cmd == CMD_GETNXT || cmd == CMD_GETPRV) begin
              focus_o <= lst_tid_i;
              if (!rf) res <= lst_tid_i;
            end else if (chk) res <= RES_DUP;
            else if (cmd == CMD_INSERT) begin
              res <= '0;
              if (cnt != 7'd64) cnt <= cnt + 7'd1;
              if (cnt == '0) focus_o <= {1'b0, tid};
            end else begin
              res <= lst_tid_i;
              if (cnt != '0) cnt <= cnt - 7'd1;
              if (cnt <= 7'd1) focus_o <= TID_NONE;
              else if (lst_tid_i == 7'd1) state <= S_REFRESH;
            end
          end else if (chk) state <= rf ? S_RWAIT : S_WAIT;
          else if (wcnt == WW'(TIMEOUT)) begin
            err_o <= 1'b1;
            res   <= RES_TMO;
            state <= S_RESP;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iof_arbiter.sv
// tb_iof_arbiter: randomized bench with a queue-based focus-list model and arbiter reference
module tb_iof_arbiter;
  import iof_pkg::*;
  localparam int NP  = 4;
  localparam int TMO = 63;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0] req = '0;
  logic [7*NP-1:0] cmd = '0;
  logic [6*NP-1:0] tid = '0;
  logic [NP-1:0] ack;
  logic [6:0] res, lst_cmd, focus;
  logic [6:0] lst_tid_in = '0;
  logic [5:0] lst_tid;
  logic busy, err;
  logic lst_done = 1'b1;
  int pass = 0, total = 0;
  logic [5:0] q[$];
  logic [6:0] fm = 7'h7F;
  logic [6:0] pend = '0;
  int dly = 0;
  bit hang = 0;
  int cyc, ncmd;
  logic [6:0] c1, c2, r;
  logic [5:0] t1;
  logic [NP-1:0] a;

  iof_arbiter #(.NPORT(NP), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .cmd_i(cmd), .tid_i(tid),
    .ack_o(ack), .res_o(res), .busy_o(busy), .lst_cmd_o(lst_cmd), .lst_tid_o(lst_tid),
    .lst_tid_i(lst_tid_in), .lst_done_i(lst_done), .focus_o(focus), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic int find(input logic [5:0] t);
    for (int k = 0; k < q.size(); k++) if (q[k] == t) return k;
    return -1;
  endfunction

  function automatic logic [6:0] walk(input logic [6:0] c, input logic [5:0] t);
    int n = q.size();
    int i = find(t);
    if (n == 0) return 7'h7F;
    if (i < 0) return {1'b0, c == CMD_GETNXT ? q[0] : q[n-1]};
    return {1'b0, c == CMD_GETNXT ? q[(i + 1) % n] : q[(i + n - 1) % n]};
  endfunction

  // focus list: ordered queue; REMOVE answers position+1, GETNXT/GETPRV walk circularly
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      dly = 0;
      lst_done = 1'b1;
      lst_tid_in = '0;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        lst_done = 1'b1;
        lst_tid_in = pend;
      end
    end else if (lst_cmd != CMD_NOP) begin
      int i;
      bit imm;
      i = find(lst_tid);
      imm = 0;
      pend = 7'h7D;
      if (lst_cmd == CMD_INSERT) begin
        if (i >= 0) imm = 1;
        else begin q.push_back(lst_tid); pend = 7'h00; end
      end else if (lst_cmd == CMD_REMOVE) begin
        if (i < 0) imm = 1;
        else begin pend = 7'(i + 1); q.delete(i); end
      end else begin
        pend = walk(lst_cmd, lst_tid);
        imm = q.size() == 0 || $urandom_range(0, 3) == 0;
      end
      if (imm) lst_tid_in = pend;
      else begin
        lst_done = 1'b0;
        dly = hang ? 1000000 : $urandom_range(1, 4) + 1;
      end
    end
  end

  task automatic expect_of(input logic [6:0] c, input logic [5:0] t, output logic [6:0] er, output logic [6:0] ef);
    int i = find(t);
    ef = fm;
    if (c < 7'd16 || c > 7'd19) er = 7'h7E;
    else if (c == CMD_INSERT) begin
      er = i >= 0 ? 7'h7D : 7'h00;
      if (i < 0 && q.size() == 0) ef = {1'b0, t};
    end else if (c == CMD_REMOVE) begin
      er = i < 0 ? 7'h7D : 7'(i + 1);
      if (i >= 0) ef = q.size() == 1 ? 7'h7F : i == 0 ? {1'b0, q[1]} : fm;
    end else begin
      er = walk(c, t);
      ef = er;
    end
  endtask

  function automatic logic [6:0] rand_illegal();
    int v = $urandom_range(0, 123);
    return 7'(v < 16 ? v : v + 4);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    hang = 0;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fm = 7'h7F;
  endtask

  task automatic run(input int p, input logic [6:0] c, input logic [5:0] t);
    @(negedge clk);
    cmd[7*p +: 7] = c;
    tid[6*p +: 6] = t;
    req[p] = 1'b1;
    cyc = 0; ncmd = 0; a = '0; r = '0; c1 = '0; c2 = '0; t1 = '0;
    while (a == '0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (lst_cmd != CMD_NOP) begin
        ncmd++;
        if (ncmd == 1) begin c1 = lst_cmd; t1 = lst_tid; end
        else c2 = lst_cmd;
      end
      a = ack;
      r = res;
    end
    req[p] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (ack !== '0) $display("FAIL reset_ack got %h want 0", ack); else pass++;
    total++; if (res !== '0) $display("FAIL reset_res got %h want 0", res); else pass++;
    total++; if (lst_cmd !== '0) $display("FAIL reset_lst_cmd got %h want 0", lst_cmd); else pass++;
    total++; if (lst_tid !== '0) $display("FAIL reset_lst_tid got %h want 0", lst_tid); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
    total++; if (focus !== 7'h7F) $display("FAIL reset_focus got %h want 7f", focus); else pass++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass++;
  endtask

  task automatic test_insert();
    run(0, CMD_INSERT, 6'd5);
    total++; if (a !== 4'b0001) $display("FAIL ins_ack got %b want 0001", a); else pass++;
    total++; if (r !== 7'h00) $display("FAIL ins_res got %h want 00", r); else pass++;
    total++; if (focus !== 7'd5) $display("FAIL ins_focus got %h want 05", focus); else pass++;
    total++; if (ncmd !== 1) $display("FAIL ins_issue_cycles got %0d want 1", ncmd); else pass++;
    total++; if ({c1, t1} !== {CMD_INSERT, 6'd5}) $display("FAIL ins_list_cmd got %0d/%0d want 16/5", c1, t1); else pass++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL ins_idle got busy %b want 0", busy); else pass++;
  endtask

  task automatic test_remove_head();
    do_reset();
    run(0, CMD_INSERT, 6'd5);
    run(1, CMD_INSERT, 6'd9);
    total++; if (focus !== 7'd5) $display("FAIL rm_focus_before got %h want 05", focus); else pass++;
    run(2, CMD_REMOVE, 6'd5);
    total++; if (a !== 4'b0100) $display("FAIL rm_ack got %b want 0100", a); else pass++;
    total++; if (r !== 7'd1) $display("FAIL rm_res got %h want 01", r); else pass++;
    total++; if (focus !== 7'd9) $display("FAIL rm_focus got %h want 09", focus); else pass++;
    total++; if (ncmd !== 2 || c2 !== CMD_GETNXT) $display("FAIL rm_refresh got %0d cmds last %0d want 2 cmds last 18", ncmd, c2); else pass++;
    run(3, CMD_REMOVE, 6'd9);
    total++; if (r !== 7'd1) $display("FAIL rm_last_res got %h want 01", r); else pass++;
    total++; if (focus !== 7'h7F) $display("FAIL rm_last_focus got %h want 7f", focus); else pass++;
    total++; if (ncmd !== 1) $display("FAIL rm_last_no_refresh got %0d cmds want 1", ncmd); else pass++;
  endtask

  task automatic test_round_robin();
    logic [6:0] cs[NP];
    logic [5:0] ts[NP];
    logic [6:0] er, ef;
    int order[$];
    int n, k, got;
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    run(3, CMD_INSERT, 6'd12);
    run(3, CMD_INSERT, 6'd40);
    fm = 7'd12;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      k = $urandom_range(0, 2);
      cs[p] = k == 0 ? rand_illegal() : k == 1 ? CMD_GETNXT : CMD_GETPRV;
      ts[p] = 6'($urandom_range(0, 63));
      cmd[7*p +: 7] = cs[p];
      tid[6*p +: 6] = ts[p];
    end
    req = '1;
    n = 0;
    while (order.size() < 5 && n < 400) begin
      @(negedge clk);
      n++;
      for (int p = 0; p < NP; p++) if (ack[p]) begin
        order.push_back(p);
        expect_of(cs[p], ts[p], er, ef);
        fm = ef;
        total++; if (res !== er) $display("FAIL rr_res port %0d got %h want %h", p, res, er); else pass++;
        if (p == 0 && order.size() == 1) begin
          cs[0] = $urandom_range(0, 1) ? CMD_GETNXT : rand_illegal();
          ts[0] = 6'd40;
          cmd[6:0] = cs[0];
          tid[5:0] = ts[0];
        end else req[p] = 1'b0;
      end
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      got = i < order.size() ? order[i] : -1;
      total++; if (got !== want[i]) $display("FAIL rr_order slot %0d got %0d want %0d", i, got, want[i]); else pass++;
    end
    total++; if (focus !== fm) $display("FAIL rr_focus got %h want %h", focus, fm); else pass++;
  endtask

  task automatic test_illegal();
    logic [6:0] f0;
    f0 = focus;
    run(2, 7'd3, 6'd7);
    total++; if (a !== 4'b0100) $display("FAIL ill_ack got %b want 0100", a); else pass++;
    total++; if (r !== 7'h7E) $display("FAIL ill_res got %h want 7e", r); else pass++;
    total++; if (cyc !== 2) $display("FAIL ill_latency got %0d want 2", cyc); else pass++;
    total++; if (ncmd !== 0) $display("FAIL ill_list_quiet got %0d cmds want 0", ncmd); else pass++;
    total++; if (focus !== f0) $display("FAIL ill_focus got %h want %h", focus, f0); else pass++;
  endtask

  task automatic test_empty_getnxt();
    do_reset();
    run(1, CMD_GETNXT, 6'd0);
    total++; if (a !== 4'b0010) $display("FAIL empty_ack got %b want 0010", a); else pass++;
    total++; if (r !== 7'h7F) $display("FAIL empty_res got %h want 7f", r); else pass++;
    total++; if (focus !== 7'h7F) $display("FAIL empty_focus got %h want 7f", focus); else pass++;
  endtask

  task automatic test_random();
    logic [6:0] c, er, ef;
    logic [5:0] t;
    int p, k;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      p = $urandom_range(0, NP - 1);
      k = $urandom_range(0, 9);
      c = k < 3 ? CMD_INSERT : k < 6 ? CMD_REMOVE : k < 8 ? CMD_GETNXT : k == 8 ? CMD_GETPRV : rand_illegal();
      t = 6'($urandom_range(0, 7));
      expect_of(c, t, er, ef);
      run(p, c, t);
      fm = ef;
      total++; if (a !== NP'(1) << p) $display("FAIL rnd_ack it %0d got %b want port %0d", it, a, p); else pass++;
      total++; if (r !== er) $display("FAIL rnd_res it %0d cmd %0d tid %0d got %h want %h", it, c, t, r, er); else pass++;
      total++; if (focus !== ef) $display("FAIL rnd_focus it %0d got %h want %h", it, focus, ef); else pass++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hang = 1;
    run(1, CMD_INSERT, 6'd3);
    total++; if (a !== 4'b0010) $display("FAIL tmo_ack got %b want 0010", a); else pass++;
    total++; if (r !== 7'h7F) $display("FAIL tmo_res got %h want 7f", r); else pass++;
    total++; if (err !== 1'b1) $display("FAIL tmo_err got %b want 1", err); else pass++;
    total++; if (cyc <= TMO || cyc > TMO + 10) $display("FAIL tmo_latency got %0d want %0d..%0d", cyc, TMO + 1, TMO + 10); else pass++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL tmo_idle got busy %b want 0", busy); else pass++;
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL tmo_sticky got %b want 1", err); else pass++;
    do_reset();
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL tmo_clear got %b want 0", err); else pass++;
  endtask

  initial begin
    test_reset();
    test_insert();
    test_remove_head();
    test_round_robin();
    test_illegal();
    test_empty_getnxt();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
